sfifo_wr_arb: RTL
=================

Name: sfifo_wr_arb

Overview:
Round-robin write arbiter that shares a single sfifo write port between NUM_REQ requesters. It grants one requester at a time for a bounded burst and stalls on fifo full. It drives w_en/din straight into the sfifo and keeps a sticky overflow flag plus a total-write counter. It sits directly in front of the sfifo write side; the read side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, data width; matches sfifo din
MAX_BURST, 4, maximum writes per grant (1..256)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  reset, synchronous, active-high
req  in  NUM_REQ  per-requester write request; held until granted
req_data  in  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
gnt  out  NUM_REQ  one-hot grant; a transfer occurs when req[i] && gnt[i]
fifo_full  in  1  sfifo full
fifo_overflow  in  1  sfifo overflow pulse
w_en  out  1  sfifo write enable
din  out  DATA_W  sfifo write data
owner  out  clog2(NUM_REQ)  current/last owner index
ovfl_err  out  1  sticky overflow flag
err_clr  in  1  clears ovfl_err
wr_cnt  out  16  total accepted writes, wraps 0xFFFF->0

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, owner=NUM_REQ-1 (so requester 0 has first priority), burst_cnt=0, ovfl_err=0, wr_cnt=0.
- While rst=1, gnt=0 and w_en=0 combinationally, even if the state register still holds BURST.
- States: IDLE, BURST.
- IDLE:
  - gnt=0, w_en=0.
  - If req!=0, pick the first set req bit scanning owner+1, owner+2, ... (mod NUM_REQ).
  - Load owner with the pick, clear burst_cnt, go to BURST.
  - The arbitration cycle moves no data.
  - If req==0, stay in IDLE; owner holds.
- BURST:
  - gnt[owner] = req[owner] && !fifo_full; all other gnt bits are 0.
  - w_en = gnt[owner]; din = req_data slice of owner. w_en and din are combinational from registered owner/state plus inputs, so there is zero-cycle latency to the sfifo.
  - On a transfer with burst_cnt==MAX_BURST-1: go to IDLE.
  - On a transfer otherwise: burst_cnt++ and stay in BURST.
  - If req[owner]==0: go to IDLE with no transfer; the burst ends early.
  - If fifo_full==1 and req[owner]==1: stall in BURST; burst_cnt holds and gnt=0.
- Result: a fully requested burst is MAX_BURST write cycles followed by 1 IDLE cycle. The rotating start point gives round-robin fairness; a lone requester is re-granted after the IDLE cycle.
- The block itself never writes while full. fifo_overflow is monitored only to catch other writers or integration bugs.
- ovfl_err:
  - Set on fifo_overflow=1.
  - Cleared on err_clr=1.
  - Set wins if both occur in the same cycle.
- wr_cnt increments on every cycle with w_en=1 and wraps.
- Requester data need not be stable outside its granted cycles.
- burst_cnt width: clog2(MAX_BURST), minimum 1 bit.

Decomposition:
- Package sfifo_arb_pkg: state enum (IDLE, BURST), WR_CNT_W=16 constant, parameter defaults.
- One sub-module, sfifo_rr_pick: combinational round-robin picker. Inputs: req vector and last index. Outputs: valid and pick index. Parameter: NUM_REQ.
- All remaining logic (FSM, counters, muxes) lives in sfifo_wr_arb.

Test Plan:
1. Reset, then req=4'b0001 held, full=0 -> IDLE 1 cycle, gnt=4'b0001 and w_en=1 for 4 cycles, IDLE 1 cycle, repeating. wr_cnt=8 after 10 cycles following reset release.
2. req=4'b1111, req_data lanes = 0x10/0x20/0x30/0x40 -> din sequence 4x10, 4x20, 4x30, 4x40, 4x10, with one idle cycle between bursts and gnt always one-hot.
3. Owner 1 mid-burst: 2 writes, then fifo_full=1 for 3 cycles -> gnt=0 and w_en=0 for those 3 cycles, owner stays 1, then exactly 2 more writes before IDLE.
4. req=4'b1100, owner 2 drops req after 1 write -> next cycle IDLE, next grant goes to requester 3, wr_cnt increments by 1 for requester 2.
5. fifo_overflow pulse -> ovfl_err=1 next cycle and stays 1. err_clr plus overflow in the same cycle -> stays 1. err_clr alone -> 0.
6. rst asserted during a burst on owner 2 with req=4'b1111 -> w_en=0 during reset. After release, the first grant goes to requester 0, and wr_cnt restarts at 0.

Source files
------------

// File: rtl/sfifo_arb_pkg.sv
// Shared types and constants for the sfifo round-robin write arbiter.
package sfifo_arb_pkg;

    // Arbiter FSM: IDLE arbitrates (no data moves), BURST streams writes.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Width of the total-write counter; it wraps silently.
    localparam int WR_CNT_W = 16;

    // Parameter defaults for the arbiter top.
    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;

endpackage : sfifo_arb_pkg

// File: rtl/sfifo_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// found scanning last+1, last+2, ... (mod NUM_REQ), with `last` itself
// checked at the lowest priority.
module sfifo_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] pick
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Scan from the farthest offset down to the nearest so the closest
    // requester after `last` is the final (winning) assignment.
    // NOTE: every output of a combinational block gets a default first;
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        valid = 1'b0;
        pick  = last;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (req[(int'(last) + off) % NUM_REQ]) begin
                valid = 1'b1;
                pick  = IDX_W'((int'(last) + off) % NUM_REQ);
            end
        end
    end

endmodule : sfifo_rr_pick

// File: rtl/sfifo_wr_arb.sv
// Round-robin write arbiter sharing one sfifo write port among NUM_REQ
// requesters. Grants one requester per bounded burst, stalls on full,
// tracks a sticky overflow flag and a wrapping total-write counter.
module sfifo_wr_arb
    import sfifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    input  logic                        fifo_full,
    input  logic                        fifo_overflow,
    output logic                        w_en,
    output logic [DATA_W-1:0]           din,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        ovfl_err,
    input  logic                        err_clr,
    output logic [WR_CNT_W-1:0]         wr_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);

    arb_state_e         state, state_nxt;
    logic [IDX_W-1:0]   owner_nxt;
    logic [BC_W-1:0]    burst_cnt, burst_nxt;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    sfifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req),
        .last  (owner),
        .valid (pick_valid),
        .pick  (pick_idx)
    );

    // Owner's data is always on din; w_en qualifies it for the sfifo.
    assign din = req_data[int'(owner)*DATA_W +: DATA_W];

    // Next-state, grant and write-enable; zero-latency path to the sfifo.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        gnt       = '0;
        w_en      = 1'b0;

        unique case (state)
            IDLE: begin
                // Arbitration cycle: choose the next owner, move no data.
                if (pick_valid) begin
                    owner_nxt = pick_idx;
                    burst_nxt = '0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (!req[owner]) begin
                    // Requester withdrew: end the burst early.
                    state_nxt = IDLE;
                end else if (!fifo_full) begin
                    gnt[owner] = 1'b1;
                    w_en       = 1'b1;
                    if (burst_cnt == BURST_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        burst_nxt = burst_cnt + BC_W'(1);
                    end
                end
                // fifo_full with req held: stall, burst_cnt holds.
            end
            default: state_nxt = IDLE;
        endcase

        // The state register may still read BURST during reset; never
        // let a grant escape in that cycle.
        if (rst) begin
            gnt  = '0;
            w_en = 1'b0;
        end
    end

    // FSM state, owner and burst counter registers.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= IDX_W'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Sticky overflow flag; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovfl_err <= 1'b0;
        end else if (fifo_overflow) begin
            ovfl_err <= 1'b1;
        end else if (err_clr) begin
            ovfl_err <= 1'b0;
        end
    end

    // Total accepted writes, wrapping at the counter width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (w_en) begin
            wr_cnt <= wr_cnt + WR_CNT_W'(1);
        end
    end

endmodule : sfifo_wr_arb
